fetch_prefetch: RTL and testbench

FETCH_PREFETCH -- requirements
Module: fetch_prefetch

---
 rtl/fetch_prefetch.sv | 111 +++++++++++
 tb/tb_fetch_prefetch.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/fetch_prefetch.sv
// fetch_prefetch: instruction prefetch unit with credit-limited FIFO and redirect squash.
// Optional FETCH_PREFETCH_ALIGN_CHECK_EN flags misaligned redirect targets and forces them to word alignment.
module fetch_prefetch #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        int_req,
    input  logic [31:0] int_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_pc_plus4,
    output logic [31:0] out_instr,
    output logic        err
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW+1:0] LIM = (AW+2)'(DEPTH);

    typedef enum logic [1:0] {BOOT, RUN, SQUASH} state_t;

    state_t        r_state, w_next;
    logic [31:0]   r_fetch_pc, r_rsp_pc;
    logic [31:0]   r_pc_q  [DEPTH];
    logic [31:0]   r_ins_q [DEPTH];
    logic [AW-1:0] r_wptr, r_rptr;
    logic [AW:0]   r_cnt;
    logic          r_inflight;
    logic          w_redir, w_push, w_pop;
    logic [31:0]   w_raw, w_target;

    assign w_redir = int_req | redirect_valid;
    assign w_raw   = int_req ? int_pc : redirect_pc;

`ifdef FETCH_PREFETCH_ALIGN_CHECK_EN
    logic r_err;
    assign w_target = {w_raw[31:2], 2'b00};
    assign err      = r_err;
    always_ff @(posedge clk) begin
        if (rst)
            r_err <= 1'b0;
        else if (w_redir && (w_raw[1:0] != 2'b00))
            r_err <= 1'b1;
    end
`else
    assign w_target = w_raw;
    assign err      = 1'b0;
`endif

    // Credit counts the response due this cycle, so a new request never overflows the FIFO.
    assign imem_req  = (r_state != BOOT) && !w_redir &&
                       (({1'b0, r_cnt} + {{(AW+1){1'b0}}, r_inflight}) < LIM);
    assign imem_addr = r_fetch_pc;

    assign out_valid    = r_cnt != '0;
    assign out_pc       = r_pc_q[r_rptr];
    assign out_instr    = r_ins_q[r_rptr];
    assign out_pc_plus4 = out_pc + 32'd4;

    assign w_push = imem_rvalid && r_inflight && (r_state == RUN) && !w_redir;
    assign w_pop  = out_valid && out_ready && !w_redir;

    always_comb begin
        w_next = RUN;
        if (w_redir && r_inflight)
            w_next = SQUASH;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= BOOT;
            r_fetch_pc <= RESET_PC;
            r_inflight <= 1'b0;
            r_cnt      <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
        end else begin
            r_state    <= w_next;
            r_inflight <= imem_req;
            if (w_redir) begin
                r_fetch_pc <= w_target;
                r_cnt      <= '0;
                r_wptr     <= '0;
                r_rptr     <= '0;
            end else begin
                if (imem_req)
                    r_fetch_pc <= r_fetch_pc + 32'd4;
                if (w_push)
                    r_wptr <= r_wptr + AW'(1);
                if (w_pop)
                    r_rptr <= r_rptr + AW'(1);
                r_cnt <= r_cnt + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
            end
        end
    end

    always_ff @(posedge clk) begin
        r_rsp_pc <= r_fetch_pc;
        if (w_push) begin
            r_pc_q[r_wptr]  <= r_rsp_pc;
            r_ins_q[r_wptr] <= imem_rdata;
        end
    end
endmodule

// File: tb/tb_fetch_prefetch.sv
// tb_fetch_prefetch: table-driven cycle vectors plus hand sequences for wrap and alignment error.
module tb_fetch_prefetch;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req, imem_rvalid = 1'b0;
    logic [31:0] imem_addr, imem_rdata = '0;
    logic        redirect_valid = 1'b0, int_req = 1'b0, out_ready = 1'b0;
    logic [31:0] redirect_pc = '0, int_pc = '0;
    logic        out_valid, err;
    logic [31:0] out_pc, out_pc_plus4, out_instr;
    int          n_chk = 0, n_err = 0;

    fetch_prefetch #(.DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .int_req(int_req), .int_pc(int_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_pc_plus4(out_pc_plus4), .out_instr(out_instr),
        .err(err)
    );

    always #5 clk = ~clk;

    // Memory answers every request one cycle later with its own address as data.
    always @(posedge clk) begin
        imem_rvalid <= imem_req;
        imem_rdata  <= imem_addr;
    end

    typedef struct {
        logic        rst, rdy, redir;
        logic [31:0] rpc;
        logic        intr;
        logic [31:0] ipc;
        logic        req;
        logic [31:0] addr;
        logic        v;
        logic [31:0] pc;
    } vec_t;

    function automatic vec_t V(input logic r, input logic rd, input logic re, input logic [31:0] rp,
                               input logic it, input logic [31:0] ip, input logic q,
                               input logic [31:0] a, input logic vv, input logic [31:0] p);
        vec_t x;
        x.rst = r; x.rdy = rd; x.redir = re; x.rpc = rp; x.intr = it; x.ipc = ip;
        x.req = q; x.addr = a; x.v = vv; x.pc = p;
        return x;
    endfunction

    function automatic vec_t N(input logic rd, input logic q, input logic [31:0] a,
                               input logic vv, input logic [31:0] p);
        return V(1'b0, rd, 1'b0, 32'h0, 1'b0, 32'h0, q, a, vv, p);
    endfunction

    task automatic step(input vec_t x);
        @(posedge clk);
        #1;
        rst = x.rst; out_ready = x.rdy;
        redirect_valid = x.redir; redirect_pc = x.rpc;
        int_req = x.intr; int_pc = x.ipc;
        @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    vec_t tbl[$];
    vec_t RS;

`ifdef FETCH_PREFETCH_ALIGN_CHECK_EN
    localparam logic        EXP_ERR  = 1'b1;
    localparam logic [31:0] EXP_MISA = 32'h100;
`else
    localparam logic        EXP_ERR  = 1'b0;
    localparam logic [31:0] EXP_MISA = 32'h102;
`endif

    initial begin
        RS = V(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        // streaming with out_ready high, then redirect and interrupt/redirect collision
        tbl.push_back(RS); tbl.push_back(RS);
        tbl.push_back(N(1, 0, 32'h0,  0, 32'h0));
        tbl.push_back(N(1, 1, 32'h0,  0, 32'h0));
        tbl.push_back(N(1, 1, 32'h4,  0, 32'h0));
        tbl.push_back(N(1, 1, 32'h8,  1, 32'h0));
        tbl.push_back(N(1, 1, 32'hC,  1, 32'h4));
        tbl.push_back(N(1, 1, 32'h10, 1, 32'h8));
        tbl.push_back(N(1, 1, 32'h14, 1, 32'hC));
        tbl.push_back(N(1, 1, 32'h18, 1, 32'h10));
        tbl.push_back(N(1, 1, 32'h1C, 1, 32'h14));
        tbl.push_back(N(1, 1, 32'h20, 1, 32'h18));
        tbl.push_back(V(0, 1, 1, 32'h100, 0, 32'h0, 0, 32'h0, 1, 32'h1C));
        tbl.push_back(N(1, 1, 32'h100, 0, 32'h0));
        tbl.push_back(N(1, 1, 32'h104, 0, 32'h0));
        tbl.push_back(N(1, 1, 32'h108, 1, 32'h100));
        tbl.push_back(V(0, 1, 1, 32'h200, 1, 32'h80, 0, 32'h0, 1, 32'h104));
        tbl.push_back(N(1, 1, 32'h80, 0, 32'h0));
        tbl.push_back(N(1, 1, 32'h84, 0, 32'h0));
        tbl.push_back(N(1, 1, 32'h88, 1, 32'h80));
        tbl.push_back(N(1, 1, 32'h8C, 1, 32'h84));
        // reset mid-stream, then fill with out_ready low and release one pop
        tbl.push_back(RS); tbl.push_back(RS);
        tbl.push_back(N(0, 0, 32'h0,  0, 32'h0));
        tbl.push_back(N(0, 1, 32'h0,  0, 32'h0));
        tbl.push_back(N(0, 1, 32'h4,  0, 32'h0));
        tbl.push_back(N(0, 1, 32'h8,  1, 32'h0));
        tbl.push_back(N(0, 1, 32'hC,  1, 32'h0));
        tbl.push_back(N(0, 0, 32'h0,  1, 32'h0));
        tbl.push_back(N(0, 0, 32'h0,  1, 32'h0));
        tbl.push_back(N(1, 0, 32'h0,  1, 32'h0));
        tbl.push_back(N(0, 1, 32'h10, 1, 32'h4));
        tbl.push_back(N(0, 0, 32'h0,  1, 32'h4));

        foreach (tbl[i]) begin
            step(tbl[i]);
            if (!tbl[i].rst) begin
                chk($sformatf("row%0d req", i), {31'b0, imem_req}, {31'b0, tbl[i].req});
                if (tbl[i].req)
                    chk($sformatf("row%0d addr", i), imem_addr, tbl[i].addr);
                chk($sformatf("row%0d valid", i), {31'b0, out_valid}, {31'b0, tbl[i].v});
                if (tbl[i].v) begin
                    chk($sformatf("row%0d pc", i), out_pc, tbl[i].pc);
                    chk($sformatf("row%0d pc4", i), out_pc_plus4, tbl[i].pc + 32'd4);
                    chk($sformatf("row%0d instr", i), out_instr, tbl[i].pc);
                end
                chk($sformatf("row%0d err", i), {31'b0, err}, 32'h0);
            end
        end

        // address wrap at the top of the space
        step(RS); step(RS);
        step(N(1, 0, 0, 0, 0));
        chk("boot req", {31'b0, imem_req}, 32'h0);
        step(V(0, 1, 1, 32'hFFFF_FFFC, 0, 0, 0, 0, 0, 0));
        chk("wrap redir req", {31'b0, imem_req}, 32'h0);
        step(N(1, 0, 0, 0, 0));
        chk("wrap addr top", imem_addr, 32'hFFFF_FFFC);
        chk("wrap req top", {31'b0, imem_req}, 32'h1);
        step(N(1, 0, 0, 0, 0));
        chk("wrap addr zero", imem_addr, 32'h0);
        step(N(1, 0, 0, 0, 0));
        chk("wrap valid", {31'b0, out_valid}, 32'h1);
        chk("wrap pc", out_pc, 32'hFFFF_FFFC);
        chk("wrap pc4", out_pc_plus4, 32'h0);

        // misaligned redirect target
        step(V(0, 1, 1, 32'h102, 0, 0, 0, 0, 0, 0));
        chk("err before", {31'b0, err}, 32'h0);
        step(N(1, 0, 0, 0, 0));
        chk("err set", {31'b0, err}, {31'b0, EXP_ERR});
        chk("misa req", {31'b0, imem_req}, 32'h1);
        chk("misa addr", imem_addr, EXP_MISA);
        step(N(1, 0, 0, 0, 0));
        step(V(0, 1, 1, 32'h300, 0, 0, 0, 0, 0, 0));
        step(N(1, 0, 0, 0, 0));
        chk("err sticky", {31'b0, err}, {31'b0, EXP_ERR});
        step(RS);
        step(N(1, 0, 0, 0, 0));
        chk("err cleared", {31'b0, err}, 32'h0);
        chk("reset valid", {31'b0, out_valid}, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
